// File: rtl/sd_sacq_seq_ctrl.sv
// Sequencer for the sd_sacq time-point coder: holds a shadow bank of host-written
// coder words, replays it on start, then steps the acquisition count per repetition.
module sd_sacq_seq_ctrl #(
  parameter int CNT_W    = 22,
  parameter int REP_W    = 16,
  parameter int NUM_LOAD = 11
) (
  input  logic             clk_sys,
  input  logic             rst_n,
  input  logic             host_we,
  input  logic [3:0]       host_addr,
  input  logic [15:0]      host_data,
  input  logic             start,
  input  logic             abort,
  output logic             sd_sacq_load,
  output logic [3:0]       sd_sacq_choice,
  output logic [15:0]      sd_sacq_data,
  output logic [CNT_W-1:0] count,
  output logic             state_start,
  output logic             busy,
  output logic             done,
  output logic [REP_W-1:0] rep_idx
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  localparam logic [3:0] LAST_K      = 4'(NUM_LOAD);
  localparam logic [3:0] ADDR_PER_LO = 4'(NUM_LOAD + 1);
  localparam logic [3:0] ADDR_PER_HI = 4'(NUM_LOAD + 2);
  localparam logic [3:0] ADDR_REP    = 4'(NUM_LOAD + 3);

  state_t           state;
  logic [15:0]      shadow [1:NUM_LOAD];
  logic [CNT_W-1:0] period;
  logic [REP_W-1:0] rep_num;

  logic             host_ok;
  logic [15:0]      first_word;
  logic [3:0]       next_k;
  logic [CNT_W-1:0] peff_m1;
  logic [REP_W-1:0] rep_last;

  assign host_ok = host_we && !busy;
  // A write to word 1 in the start cycle must reach the coder on the first replay beat.
  assign first_word = (host_ok && host_addr == 4'd1) ? host_data : shadow[1];
  assign next_k     = sd_sacq_choice + 4'd1;
  assign peff_m1    = (period == '0) ? '0 : period - CNT_W'(1);
  assign rep_last   = rep_num - REP_W'(1);

  always_ff @(posedge clk_sys) begin
    if (!rst_n) begin
      for (int i = 1; i <= NUM_LOAD; i++) shadow[i] <= '0;
      period  <= '0;
      rep_num <= '0;
    end else if (host_ok) begin
      if (host_addr >= 4'd1 && host_addr <= LAST_K)
        shadow[host_addr] <= host_data;
      else if (host_addr == ADDR_PER_LO)
        period[15:0] <= host_data;
      else if (host_addr == ADDR_PER_HI)
        period[CNT_W-1:16] <= host_data[CNT_W-17:0];
      else if (host_addr == ADDR_REP)
        rep_num <= host_data[REP_W-1:0];
    end
  end

  always_ff @(posedge clk_sys) begin
    if (!rst_n || abort) begin
      state          <= IDLE;
      sd_sacq_load   <= 1'b0;
      sd_sacq_choice <= '0;
      sd_sacq_data   <= '0;
      count          <= '0;
      state_start    <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      rep_idx        <= '0;
    end else begin
      done        <= 1'b0;
      state_start <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state          <= LOAD;
            busy           <= 1'b1;
            sd_sacq_load   <= 1'b1;
            sd_sacq_choice <= 4'd1;
            sd_sacq_data   <= first_word;
          end
        end
        LOAD: begin
          if (sd_sacq_choice == LAST_K) begin
            sd_sacq_load   <= 1'b0;
            sd_sacq_choice <= '0;
            sd_sacq_data   <= '0;
            count          <= '0;
            rep_idx        <= '0;
            if (rep_num == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state       <= RUN;
              state_start <= 1'b1;
            end
          end else begin
            sd_sacq_choice <= next_k;
            sd_sacq_data   <= shadow[next_k];
          end
        end
        RUN: begin
          if (count == peff_m1) begin
            count <= '0;
            if (rep_idx == rep_last) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              rep_idx     <= rep_idx + REP_W'(1);
              state_start <= 1'b1;
            end
          end else begin
            count <= count + CNT_W'(1);
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
